// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// register-address width and the load-use match rule.
package pipe_ctrl_pkg;

   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_FLUSH    = 2'd2
   } state_t;

   // x0 is hardwired to zero, so a load into it never creates a dependency.
   function automatic logic load_use_hit(input logic                  memread,
                                         input logic [REG_ADDR_W-1:0] rd,
                                         input logic [REG_ADDR_W-1:0] rs1,
                                         input logic [REG_ADDR_W-1:0] rs2);
      return memread && (rd != '0) && ((rd == rs1) || (rd == rs2));
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signals between the pipeline datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
);
   logic [REG_ADDR_W-1:0] if_id_rs1;
   logic [REG_ADDR_W-1:0] if_id_rs2;
   logic [REG_ADDR_W-1:0] id_ex_rd;
   logic                  id_ex_memread;
   logic                  branch_taken;
   // dmem_req/dmem_ready: an access pending in EX/MEM completes in the cycle
   // both are high; while req is high and ready low, the pipeline is frozen.
   logic                  dmem_req;
   logic                  dmem_ready;

   logic                  pc_hazard;
   logic                  if_id_hazard;
   logic                  if_id_flush;
   logic                  id_ex_bubble;
   logic                  ex_mem_bubble;
   logic                  pipe_en;
   logic                  mem_timeout;
   logic [CNT_W-1:0]      stall_cnt;
   logic [CNT_W-1:0]      flush_cnt;

   modport master (
      output if_id_rs1, if_id_rs2, id_ex_rd, id_ex_memread, branch_taken,
             dmem_req, dmem_ready,
      input  pc_hazard, if_id_hazard, if_id_flush, id_ex_bubble, ex_mem_bubble,
             pipe_en, mem_timeout, stall_cnt, flush_cnt
   );

   modport slave (
      input  if_id_rs1, if_id_rs2, id_ex_rd, id_ex_memread, branch_taken,
             dmem_req, dmem_ready,
      output pc_hazard, if_id_hazard, if_id_flush, id_ex_bubble, ex_mem_bubble,
             pipe_en, mem_timeout, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_cnt #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, taken-branch flush and
// load-use stall, with stall/flush performance counters.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W        = 32,
   parameter int MEM_WAIT_MAX = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   pipe_hazard_ctrl_if.slave        hz,
   output state_t                   dbg_state
);

   localparam int                  WAIT_W    = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
   localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

   state_t            state_q;
   state_t            state_d;
   logic [WAIT_W-1:0] wait_q;
   logic [WAIT_W-1:0] wait_d;
   logic              timeout_q;
   logic              timeout_set;

   logic              pc_hz;
   logic              ifid_hz;
   logic              ifid_fl;
   logic              idex_bb;
   logic              exmem_bb;
   logic              pen;
   logic              mem_block;
   logic              load_use;

   assign mem_block = hz.dmem_req && !hz.dmem_ready;
   assign load_use  = load_use_hit(hz.id_ex_memread, hz.id_ex_rd, hz.if_id_rs1, hz.if_id_rs2);

   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      timeout_set = 1'b0;
      pc_hz       = 1'b0;
      ifid_hz     = 1'b0;
      ifid_fl     = 1'b0;
      idex_bb     = 1'b0;
      exmem_bb    = 1'b0;
      pen         = 1'b1;

      unique case (state_q)
         ST_RUN: begin
            if (mem_block) begin
               pc_hz   = 1'b1;
               ifid_hz = 1'b1;
               pen     = 1'b0;
               wait_d  = '0;
               state_d = ST_MEM_WAIT;
            end else if (hz.branch_taken) begin
               ifid_fl  = 1'b1;
               idex_bb  = 1'b1;
               exmem_bb = 1'b1;
               state_d  = ST_FLUSH;
            end else if (load_use) begin
               pc_hz   = 1'b1;
               ifid_hz = 1'b1;
               idex_bb = 1'b1;
            end
         end

         // Branches are ignored here: EX/MEM is frozen, so the branch is
         // still presented once the pipeline resumes.
         ST_MEM_WAIT: begin
            if (hz.dmem_ready) begin
               state_d = ST_RUN;
            end else if (wait_q == WAIT_LAST) begin
               timeout_set = 1'b1;
               state_d     = ST_RUN;
            end else begin
               pc_hz   = 1'b1;
               ifid_hz = 1'b1;
               pen     = 1'b0;
               wait_d  = wait_q + 1'b1;
            end
         end

         // ID/EX and EX/MEM hold bubbles this cycle, so memory wait and
         // load-use are not evaluated; only a new taken branch matters.
         ST_FLUSH: begin
            if (hz.branch_taken) begin
               ifid_fl  = 1'b1;
               idex_bb  = 1'b1;
               exmem_bb = 1'b1;
               state_d  = ST_FLUSH;
            end else begin
               state_d = ST_RUN;
            end
         end

         default: state_d = ST_RUN;
      endcase

      if (rst) begin
         pc_hz    = 1'b0;
         ifid_hz  = 1'b0;
         ifid_fl  = 1'b0;
         idex_bb  = 1'b0;
         exmem_bb = 1'b0;
         pen      = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_RUN;
         wait_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         if (timeout_set) begin
            timeout_q <= 1'b1;
         end
      end
   end

   sat_cnt #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .clr (rst),
      .inc (pc_hz),
      .cnt (hz.stall_cnt)
   );

   sat_cnt #(.W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .clr (rst),
      .inc (ifid_fl),
      .cnt (hz.flush_cnt)
   );

   assign hz.pc_hazard     = pc_hz;
   assign hz.if_id_hazard  = ifid_hz;
   assign hz.if_id_flush   = ifid_fl;
   assign hz.id_ex_bubble  = idex_bb;
   assign hz.ex_mem_bubble = exmem_bb;
   assign hz.pipe_en       = pen;
   assign hz.mem_timeout   = timeout_q;
   assign dbg_state        = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized traffic compared against a behavioural model.
module tb_pipe_hazard_ctrl;
   import pipe_ctrl_pkg::*;

   localparam int CNT_W   = 5;
   localparam int MAX     = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   // ---------------- clock / reset ----------------
   logic   clk = 1'b0;
   logic   rst;
   state_t dbg_state;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

   pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_WAIT_MAX(MAX)) dut (
      .clk       (clk),
      .rst       (rst),
      .hz        (hz),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int         pass_cnt  = 0;
   int         total_cnt = 0;
   logic [5:0] exp_q[$];
   logic [5:0] obs_comb;   // {pc_hazard, if_id_hazard, if_id_flush, id_ex_bubble, ex_mem_bubble, pipe_en}

   // behavioural model: waiting / flushing flags, cycles already spent waiting
   bit m_wait;
   int m_wait_cyc;
   bit m_flushing;
   int m_stall;
   int m_flush;
   bit m_timeout;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic state_t model_state();
      if (m_wait)     return ST_MEM_WAIT;
      if (m_flushing) return ST_FLUSH;
      return ST_RUN;
   endfunction

   task automatic model_step(input bit r, input bit mr, input int rd, input int rs1, input int rs2,
                             input bit br, input bit req, input bit rdy, output logic [5:0] e);
      bit stall, fl, bub, en;
      stall = 0; fl = 0; bub = 0; en = 1;
      if (r) begin
         m_wait = 0; m_wait_cyc = 0; m_flushing = 0;
         m_stall = 0; m_flush = 0; m_timeout = 0;
         e = 6'b000001;
         return;
      end
      if (m_wait) begin
         if (rdy) begin
            m_wait = 0;
         end else if (m_wait_cyc + 1 == MAX) begin
            m_wait    = 0;
            m_timeout = 1;
         end else begin
            stall = 1; en = 0;
            m_wait_cyc++;
         end
      end else if (m_flushing) begin
         fl = br;
         m_flushing = br;
      end else if (req && !rdy) begin
         stall = 1; en = 0;
         m_wait = 1; m_wait_cyc = 0;
      end else if (br) begin
         fl = 1;
         m_flushing = 1;
      end else if (mr && rd != 0 && (rd == rs1 || rd == rs2)) begin
         stall = 1; bub = 1;
      end
      e = {stall, stall, fl, bub | fl, fl, en};
      if (stall && m_stall < CNT_MAX) m_stall++;
      if (fl && m_flush < CNT_MAX)    m_flush++;
   endtask

   // ---------------- driver ----------------
   task automatic cyc(input bit r, input bit mr, input int rd, input int rs1, input int rs2,
                      input bit br, input bit req, input bit rdy);
      logic [5:0] e;
      @(negedge clk);
      rst              = r;
      hz.id_ex_memread = mr;
      hz.id_ex_rd      = 5'(rd);
      hz.if_id_rs1     = 5'(rs1);
      hz.if_id_rs2     = 5'(rs2);
      hz.branch_taken  = br;
      hz.dmem_req      = req;
      hz.dmem_ready    = rdy;
      #1;
      model_step(r, mr, rd, rs1, rs2, br, req, rdy, e);
      exp_q.push_back(e);
      obs_comb = {hz.pc_hazard, hz.if_id_hazard, hz.if_id_flush,
                  hz.id_ex_bubble, hz.ex_mem_bubble, hz.pipe_en};
      check("comb_outputs", 32'(obs_comb), 32'(exp_q.pop_front()));
      @(posedge clk);
      #1;
      check("stall_cnt", 32'(hz.stall_cnt), m_stall);
      check("flush_cnt", 32'(hz.flush_cnt), m_flush);
      check("mem_timeout", 32'(hz.mem_timeout), 32'(m_timeout));
      check("state", 32'(dbg_state), 32'(model_state()));
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      hz.id_ex_memread = 0; hz.id_ex_rd = 0; hz.if_id_rs1 = 0; hz.if_id_rs2 = 0;
      hz.branch_taken = 0; hz.dmem_req = 0; hz.dmem_ready = 0;
      m_wait = 0; m_wait_cyc = 0; m_flushing = 0; m_stall = 0; m_flush = 0; m_timeout = 0;

      // reset state and idle outputs
      do_reset();
      check("reset_outputs", 32'(obs_comb), 32'(6'b000001));
      check("reset_state", 32'(dbg_state), 32'(ST_RUN));
      idle();
      check("idle_outputs", 32'(obs_comb), 32'(6'b000001));

      // load-use on rs2
      cyc(0, 1, 5, 3, 5, 0, 0, 0);
      check("load_use_outputs", 32'(obs_comb), 32'(6'b110101));
      check("load_use_stall_cnt", 32'(hz.stall_cnt), 32'd1);
      idle();
      check("load_use_one_cycle", 32'(obs_comb), 32'(6'b000001));

      // load into x0 never stalls
      cyc(0, 1, 0, 0, 0, 0, 0, 0);
      check("x0_load_no_stall", 32'(obs_comb), 32'(6'b000001));

      // memory wait, ready low for three cycles
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 0, 0, 1, 0);
         check("mem_wait_freeze", 32'(obs_comb), 32'(6'b110000));
      end
      cyc(0, 0, 0, 0, 0, 0, 1, 1);
      check("mem_wait_release", 32'(obs_comb), 32'(6'b000001));
      check("mem_wait_stall_cnt", 32'(hz.stall_cnt), 32'd3);
      check("mem_wait_back_run", 32'(dbg_state), 32'(ST_RUN));

      // branch and load-use together: flush wins, FLUSH suppresses detection
      do_reset();
      cyc(0, 1, 5, 0, 5, 1, 0, 0);
      check("branch_lu_outputs", 32'(obs_comb), 32'(6'b001111));
      check("branch_lu_state", 32'(dbg_state), 32'(ST_FLUSH));
      cyc(0, 1, 5, 0, 5, 0, 0, 0);
      check("flush_suppress_lu", 32'(obs_comb), 32'(6'b000001));
      check("flush_cnt_one", 32'(hz.flush_cnt), 32'd1);
      check("flush_no_stall", 32'(hz.stall_cnt), 32'd0);

      // branch during memory wait is deferred until the pipeline resumes
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 1, 1, 0);
      check("branch_ignored_in_wait", 32'(obs_comb), 32'(6'b110000));
      cyc(0, 0, 0, 0, 0, 1, 1, 1);
      check("branch_ignored_on_ready", 32'(obs_comb), 32'(6'b000001));
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      check("branch_after_resume", 32'(obs_comb), 32'(6'b001111));

      // timeout: ready held low
      do_reset();
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      check("timeout_release", 32'(obs_comb), 32'(6'b000001));
      check("timeout_flag", 32'(hz.mem_timeout), 32'd1);
      check("timeout_state_run", 32'(dbg_state), 32'(ST_RUN));
      for (int i = 0; i < 3; i++) idle();
      check("timeout_sticky", 32'(hz.mem_timeout), 32'd1);

      // reset in the second MEM_WAIT cycle
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      cyc(1, 0, 0, 0, 0, 0, 1, 0);
      check("rst_mid_wait_outputs", 32'(obs_comb), 32'(6'b000001));
      check("rst_mid_wait_state", 32'(dbg_state), 32'(ST_RUN));
      check("rst_mid_wait_stall_cnt", 32'(hz.stall_cnt), 32'd0);
      check("rst_clears_timeout", 32'(hz.mem_timeout), 32'd0);
      idle();
      check("after_rst_pipe_en", 32'(obs_comb), 32'(6'b000001));

      // counter saturation
      do_reset();
      for (int i = 0; i < CNT_MAX + 6; i++) cyc(0, 1, 7, 7, 1, 0, 0, 0);
      check("stall_cnt_saturates", 32'(hz.stall_cnt), 32'(CNT_MAX));

      // randomized traffic
      do_reset();
      for (int i = 0; i < 500; i++) begin
         cyc(($urandom_range(0, 99) < 2),
             $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             ($urandom_range(0, 99) < 15),
             ($urandom_range(0, 99) < 30),
             $urandom_range(0, 1));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: CNT_W, default 32, width of performance counters.
REQ-002 Parameter: MEM_WAIT_MAX, default 255, max MEM_WAIT cycles before timeout.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 if_id_rs1, if_id_rs2  in  5 each  source registers of instruction in IF/ID.
REQ-006 id_ex_rd  in  5  destination register in ID/EX; id_ex_memread  in  1  ID/EX holds a load.
REQ-007 branch_taken  in  1  taken branch/jump resolved in EX/MEM stage.
REQ-008 dmem_req  in  1  EX/MEM access pending; dmem_ready  in  1  data memory done.
REQ-009 pc_hazard  out  1  freeze PC register.
REQ-010 if_id_hazard  out  1  hold IF/ID register; if_id_flush  out  1  clear IF/ID to 0.
REQ-011 id_ex_bubble  out  1  zero control inputs into ID/EX; ex_mem_bubble  out  1  zero control inputs into EX/MEM.
REQ-012 pipe_en  out  1  enable for ID/EX, EX/MEM, MEM/WB registers.
REQ-013 mem_timeout  out  1  sticky error; stall_cnt, flush_cnt  out  CNT_W  perf counters.

Function
REQ-014 FSM states: RUN, MEM_WAIT, FLUSH; stall/flush outputs combinational from state and inputs.
REQ-015 Priority per cycle: memory wait > branch flush > load-use stall.
REQ-016 RUN, dmem_req=1 and dmem_ready=0: pc_hazard=if_id_hazard=1, pipe_en=0, go MEM_WAIT.
REQ-017 MEM_WAIT: same outputs as REQ-016; on dmem_ready=1 drive pipe_en=1, no hazard, go RUN.
REQ-018 MEM_WAIT wait counter increments per cycle, cleared on entry; reaching MEM_WAIT_MAX sets mem_timeout, returns to RUN with pipe_en=1.
REQ-019 branch_taken=1 (in RUN, no memory wait): if_id_flush=id_ex_bubble=ex_mem_bubble=1, pc_hazard=0, go FLUSH.
REQ-020 FLUSH lasts exactly one cycle: load-use detection suppressed, pipe_en=1, then RUN; branch_taken in FLUSH is processed as in RUN.
REQ-021 Load-use (RUN): id_ex_memread=1, id_ex_rd!=0, id_ex_rd equals if_id_rs1 or if_id_rs2 -> pc_hazard=if_id_hazard=id_ex_bubble=1 for that cycle only; state stays RUN.
REQ-022 id_ex_rd=0 never produces a stall.
REQ-023 branch_taken during MEM_WAIT is ignored; it is taken when pipeline resumes (EX/MEM frozen, input still high).
REQ-024 Idle outputs: pipe_en=1, all others 0.
REQ-025 stall_cnt increments each cycle pc_hazard=1; flush_cnt increments each cycle if_id_flush=1; both saturate at all-ones.
REQ-026 mem_timeout clears only on rst.

Reset
REQ-027 rst=1 at clock edge: state=RUN, wait counter=0, stall_cnt=0, flush_cnt=0, mem_timeout=0.
REQ-028 While rst=1 outputs: pipe_en=1, hazard/flush/bubble outputs 0.
REQ-029 rst mid-MEM_WAIT or mid-FLUSH aborts it; next cycle in RUN.

Structure
REQ-030 Shared package pipe_ctrl_pkg holds state enum encoding and REG_ADDR_W=5.
REQ-031 Counters use one sub-module sat_cnt (parameter width, inc, sync clear), instanced twice.

Verification
REQ-032 Load-use: id_ex_memread=1, id_ex_rd=5, if_id_rs2=5 -> one cycle pc_hazard=if_id_hazard=id_ex_bubble=1, stall_cnt=1.
REQ-033 x0 load: id_ex_memread=1, id_ex_rd=0, if_id_rs1=0 -> no stall, pipe_en=1.
REQ-034 Memory wait: dmem_req=1, dmem_ready low 3 cycles -> pipe_en=0 for 3 cycles, stall_cnt=3, RUN after ready.
REQ-035 Branch + load-use together: branch_taken=1 plus REQ-032 hazard -> flush outputs only, no stall, next cycle FLUSH suppresses detection, flush_cnt=1.
REQ-036 Timeout: MEM_WAIT_MAX=4, dmem_ready held 0 -> after 4 cycles mem_timeout=1 and RUN; stays 1 until rst.
REQ-037 Reset mid-wait: rst=1 in 2nd MEM_WAIT cycle -> next cycle RUN, counters 0, pipe_en=1.
